// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_e : fetch FSM encoding (IDLE / WAIT / DROP)
//   fetch_entry_t : one FIFO entry, {pc, inst}
//   INST_BYTES    : PC increment per fetched instruction
//   NOP           : canonical no-op encoding (addi x0, x0, 0)
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no cache request outstanding
        WAIT = 2'd1,   // one request outstanding, its response will be kept
        DROP = 2'd2    // one request outstanding, its response is stale
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int          INST_BYTES = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous instruction FIFO between the fetch FSM and decode.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   push_i        : write wdata_i at the tail (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the FIFO at the next edge; wins over push/pop
//   wdata_i       : entry to write
//   rdata_o       : head entry, read straight from the storage array
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries (0..DEPTH)
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign count_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = rptr_q + (AW+1)'(do_pop);
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: an entry is only visible once the write
    // pointer has moved past it.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end sitting directly upstream of the I-cache.
// Issues single-outstanding word reads, buffers {pc, inst} pairs in a
// small FIFO for decode, and handles redirects by flushing the FIFO and
// dropping any in-flight response.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   ic_oe / ic_addr    : one-cycle read request and its word address
//   ic_valid / ic_rdata: read response, 1 or more cycles after ic_oe
//   redirect(_pc)      : new fetch path from execute (bits [1:0] ignored)
//   out_valid/out_ready: head of the instruction FIFO towards decode
//   out_inst / out_pc  : head instruction and its byte PC
// Handshake: an entry moves to decode on every clock edge where
// out_valid and out_ready are both 1; out_valid never depends on
// out_ready, and out_inst/out_pc are stable while out_valid is 1 and
// not accepted (until a redirect flushes the FIFO).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          MEM_SCALE = 27,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ic_oe,
    output logic [MEM_SCALE-1:0] ic_addr,
    input  logic [31:0]          ic_rdata,
    input  logic                 ic_valid,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_wdata;
    fetch_entry_t  fifo_rdata;
    logic [CW:0]   occupancy;

    assign ic_addr   = fetch_pc_q[MEM_SCALE+1:2];
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_ready && !fifo_empty;
    assign out_pc    = fifo_rdata.pc;
    assign out_inst  = fifo_rdata.inst;

    // Slots that will be taken after this edge if no new request is made:
    // stored entries, plus the response landing now in WAIT, minus the pop.
    // A new request is only allowed if that still leaves room for its data,
    // so a push can never meet a full FIFO.
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(state_q == WAIT)
                     - (CW+1)'(fifo_pop);

    // A request is never raised while one is outstanding and unanswered:
    // the cache may be mid-refill and must keep seeing the same address.
    assign ic_oe = rst && !redirect
                && ((state_q == IDLE) || (state_q == WAIT && ic_valid))
                && (occupancy < (CW+1)'(DEPTH));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        fifo_push  = 1'b0;
        fifo_wdata = '{pc: req_pc_q, inst: ic_rdata};

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // An answer in the redirect cycle belongs to the old path.
            if (state_q == WAIT) begin
                state_d = ic_valid ? IDLE : DROP;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ic_oe) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (ic_valid) begin
                        fifo_push = 1'b1;
                        if (ic_oe) begin
                            req_pc_d   = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (ic_valid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Redirect targets are word aligned; the FIFO never fills past the
    // issue gate, so its full flag has no consumer here.
    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], fifo_full};

endmodule
